// File: rtl/ddr3_user_port_arbiter.sv
// Round-robin burst arbiter sharing the ddr3_memory_controller user port among
// NUM_PORTS requesters, with phase-paced beats and a tagged read-return pipeline.
module ddr3_user_port_arbiter #(
  parameter int NUM_PORTS        = 2,
  parameter int ADDR_WIDTH       = 17,
  parameter int DQ_BITWIDTH      = 16,
  parameter int BURST_WIDTH      = 4,
  parameter int MAX_BURST        = 8,
  parameter int READ_LATENCY     = 2,
  parameter int STATE_WRITE_DATA = 8,
  parameter int STATE_READ_DATA  = 11,
  parameter int STATE_WIDTH      = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               req,
  input  logic [NUM_PORTS-1:0]               is_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_PORTS*DQ_BITWIDTH-1:0]   wdata,
  input  logic [NUM_PORTS*BURST_WIDTH-1:0]   burst_len,
  output logic [NUM_PORTS-1:0]               grant,
  output logic [NUM_PORTS-1:0]               beat_ack,
  output logic [DQ_BITWIDTH-1:0]             rdata,
  output logic [NUM_PORTS-1:0]               rvalid,
  input  logic [STATE_WIDTH-1:0]             main_state,
  input  logic                               clk_slow_posedge,
  input  logic                               clk180_slow_posedge,
  output logic                               write_enable,
  output logic                               read_enable,
  output logic [ADDR_WIDTH-1:0]              i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]             data_to_ram,
  input  logic [DQ_BITWIDTH-1:0]             data_from_ram
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [BURST_WIDTH-1:0] MAX_LEN = BURST_WIDTH'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           owner_q, owner_d, ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BURST_WIDTH-1:0]  remain_q, remain_d;

  logic [PW-1:0]           pick, cand;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [BURST_WIDTH-1:0]  sel_len, clamped_len;
  logic                    sel_write;
  logic [DQ_BITWIDTH-1:0]  own_wdata;
  logic [NUM_PORTS-1:0]    owner_oh;
  logic                    wr_accept, rd_accept, accept;

  logic [READ_LATENCY-1:0] pipe_v_q;
  logic [PW-1:0]           pipe_tag_q [READ_LATENCY];
  logic                    pipe_busy;
  logic [DQ_BITWIDTH-1:0]  rdata_q;
  logic [NUM_PORTS-1:0]    rvalid_q;

  // Round-robin search starting one past the last served port.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_write = 1'b0;
    own_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick == PW'(p)) begin
        sel_addr  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = burst_len[p*BURST_WIDTH +: BURST_WIDTH];
        sel_write = is_write[p];
      end
      if (owner_q == PW'(p)) own_wdata = wdata[p*DQ_BITWIDTH +: DQ_BITWIDTH];
    end
    if (sel_len == '0)          clamped_len = BURST_WIDTH'(1);
    else if (sel_len > MAX_LEN) clamped_len = MAX_LEN;
    else                        clamped_len = sel_len;
  end

  // Reset gates accepts so an aborted burst produces no acknowledge in the reset cycle.
  assign wr_accept = (state_q == WRITE) && (main_state == STATE_WIDTH'(STATE_WRITE_DATA)) &&
                     (clk_slow_posedge || clk180_slow_posedge) && !reset;
  assign rd_accept = (state_q == READ) && (main_state == STATE_WIDTH'(STATE_READ_DATA)) &&
                     clk_slow_posedge && !reset;
  assign accept    = wr_accept || rd_accept;
  assign owner_oh  = NUM_PORTS'(1) << owner_q;
  assign pipe_busy = |pipe_v_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= PW'(NUM_PORTS - 1);
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d  = pick;
        addr_d   = sel_addr;
        remain_d = clamped_len;
        state_d  = sel_write ? WRITE : READ;
      end
      WRITE, READ: if (accept) begin
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == BURST_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN: if (!pipe_busy) begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant               = '0;
    beat_ack            = '0;
    write_enable        = 1'b0;
    read_enable         = 1'b0;
    i_user_data_address = '0;
    data_to_ram         = '0;
    case (state_q)
      WRITE: begin
        grant               = owner_oh;
        write_enable        = 1'b1;
        i_user_data_address = addr_q;
        data_to_ram         = own_wdata;
        beat_ack            = accept ? owner_oh : '0;
      end
      READ: begin
        grant               = owner_oh;
        read_enable         = 1'b1;
        i_user_data_address = addr_q;
        beat_ack            = accept ? owner_oh : '0;
      end
      DRAIN:   grant = owner_oh;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      pipe_v_q[0] <= rd_accept;
      for (int i = 1; i < READ_LATENCY; i++) pipe_v_q[i] <= pipe_v_q[i-1];
      rvalid_q <= pipe_v_q[READ_LATENCY-1] ? (NUM_PORTS'(1) << pipe_tag_q[READ_LATENCY-1]) : '0;
      if (pipe_v_q[READ_LATENCY-1]) rdata_q <= data_from_ram;
    end
  end

  // NOTE: tag storage is not reset; the valid bits alone decide whether a tag is used.
  always_ff @(posedge clk) begin
    pipe_tag_q[0] <= owner_q;
    for (int i = 1; i < READ_LATENCY; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Self-checking bench: directed scenarios plus random bursts against a
// transaction-level model of grant order, beat pacing and read return timing.
module tb_ddr3_user_port_arbiter;

  localparam int NP = 2, AW = 17, DW = 16, BW = 4, MAXB = 8, RL = 2;
  localparam int SWD = 8, SRD = 11, SW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req, is_write, grant, beat_ack, rvalid;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [NP*BW-1:0]  burst_len;
  logic [DW-1:0]     rdata, data_to_ram, data_from_ram;
  logic [SW-1:0]     main_state;
  logic              clk_slow_posedge, clk180_slow_posedge, write_enable, read_enable;
  logic [AW-1:0]     i_user_data_address;

  ddr3_user_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DQ_BITWIDTH(DW), .BURST_WIDTH(BW),
    .MAX_BURST(MAXB), .READ_LATENCY(RL), .STATE_WRITE_DATA(SWD),
    .STATE_READ_DATA(SRD), .STATE_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .is_write(is_write), .addr(addr),
    .wdata(wdata), .burst_len(burst_len), .grant(grant), .beat_ack(beat_ack),
    .rdata(rdata), .rvalid(rvalid), .main_state(main_state),
    .clk_slow_posedge(clk_slow_posedge), .clk180_slow_posedge(clk180_slow_posedge),
    .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .data_to_ram(data_to_ram),
    .data_from_ram(data_from_ram)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    int          port;
  } ret_t;

  int checks = 0, errors = 0, cyc = 0, rr_ptr = NP - 1;
  bit cfg_write [NP];
  int cfg_addr  [NP];
  int cfg_bl    [NP];
  logic [DW-1:0] wbeat [MAXB];
  logic [DW-1:0] rbeat [MAXB];
  ret_t pending[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    return NP'(1) << p;
  endfunction

  function automatic int clamp(input int b);
    if (b == 0) return 1;
    if (b > MAXB) return MAXB;
    return b;
  endfunction

  function automatic int pick(input logic [NP-1:0] m);
    for (int i = 1; i <= NP; i++)
      if (m[(rr_ptr + i) % NP]) return (rr_ptr + i) % NP;
    return -1;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_ports(input logic [NP-1:0] m);
    req = m;
    for (int p = 0; p < NP; p++) begin
      is_write[p]            = cfg_write[p];
      addr[p*AW +: AW]       = AW'(cfg_addr[p]);
      burst_len[p*BW +: BW]  = BW'(cfg_bl[p]);
    end
  endtask

  // The controller presents a read beat RL cycles after its accept.
  task automatic drive_dfr();
    data_from_ram = DW'($urandom);
    foreach (pending[i]) if (pending[i].due - 1 == cyc) data_from_ram = pending[i].data;
  endtask

  task automatic check_returns();
    logic [NP-1:0] exp_v;
    exp_v = '0;
    if (pending.size() > 0 && pending[0].due == cyc) begin
      exp_v = oh(pending[0].port);
      check("rdata", 32'(rdata), 32'(pending[0].data));
      void'(pending.pop_front());
    end
    check("rvalid", 32'(rvalid), 32'(exp_v));
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    req   = '0;
    next_cycle();
    reset = 1'b0;
    rr_ptr = NP - 1;
    pending.delete();
  endtask

  task automatic do_burst(input logic [NP-1:0] mask, input bit force_ms);
    int own, n, done, a, release_c;
    bit wr, acc, released;
    logic [SW-1:0] code;
    ret_t r;
    own = pick(mask);
    wr  = cfg_write[own];
    n   = clamp(cfg_bl[own]);
    a   = cfg_addr[own];
    done = 0; released = 0; release_c = -1;
    code = wr ? SW'(SWD) : SW'(SRD);
    next_cycle();
    drive_ports(mask);
    main_state = code; clk_slow_posedge = 1'b1; clk180_slow_posedge = 1'b1;
    drive_dfr();
    #1;
    check("idle_grant", 32'(grant), 0);
    check("idle_ack", 32'(beat_ack), 0);
    check("idle_en", {30'd0, write_enable, read_enable}, 0);
    check_returns();
    for (int k = 0; k < 400 && !released; k++) begin
      next_cycle();
      if (k == 1) req = '0;
      if (done < n) begin
        main_state = (force_ms || $urandom_range(1, 0) == 1) ? code : SW'($urandom_range(31, 0));
        clk_slow_posedge    = 1'($urandom);
        clk180_slow_posedge = 1'($urandom);
      end else begin
        main_state = code; clk_slow_posedge = 1'b1; clk180_slow_posedge = 1'b1;
      end
      for (int p = 0; p < NP; p++) wdata[p*DW +: DW] = DW'($urandom);
      if (done < n) wdata[own*DW +: DW] = wbeat[done];
      drive_dfr();
      #1;
      if (done < n) begin
        acc = wr ? (main_state == SW'(SWD) && (clk_slow_posedge || clk180_slow_posedge))
                 : (main_state == SW'(SRD) && clk_slow_posedge);
        check("grant", 32'(grant), 32'(oh(own)));
        check("wr_en", 32'(write_enable), 32'(wr));
        check("rd_en", 32'(read_enable), 32'(!wr));
        check("addr", 32'(i_user_data_address), 32'(a));
        if (wr) check("data_to_ram", 32'(data_to_ram), 32'(wbeat[done]));
        check("beat_ack", 32'(beat_ack), acc ? 32'(oh(own)) : 0);
        if (acc) begin
          if (!wr) begin
            r.due = cyc + RL + 1; r.data = rbeat[done]; r.port = own;
            pending.push_back(r);
          end
          done++;
          a = (a + 1) % (1 << AW);
          if (done == n) release_c = cyc + (wr ? 2 : RL + 2);
        end
      end else begin
        check("post_ack", 32'(beat_ack), 0);
        check("post_en", {30'd0, write_enable, read_enable}, 0);
        check("post_grant", 32'(grant), (cyc < release_c) ? 32'(oh(own)) : 0);
        if (cyc >= release_c) released = 1'b1;
      end
      check_returns();
    end
    check("burst_done", 32'(released), 1);
    check("returns_left", 32'(pending.size()), 0);
    pending.delete();
    rr_ptr = own;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seg_owner[$];
    logic [NP-1:0] prev_g;
    bit got;
    reset = 1'b1; req = '0; is_write = '0; addr = '0; wdata = '0; burst_len = '0;
    main_state = '0; clk_slow_posedge = 1'b0; clk180_slow_posedge = 1'b0; data_from_ram = '0;
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(beat_ack), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_en", {30'd0, write_enable, read_enable}, 0);
    check("rst_addr", 32'(i_user_data_address), 0);
    check("rst_wdata", 32'(data_to_ram), 0);

    // Single write burst on port 0
    cfg_write[0] = 1; cfg_addr[0] = 0; cfg_bl[0] = 3;
    cfg_write[1] = 0; cfg_addr[1] = 0; cfg_bl[1] = 1;
    wbeat[0] = 16'h0100; wbeat[1] = 16'h0302; wbeat[2] = 16'h0504;
    do_burst(2'b01, 1'b1);

    // Read latency on port 1
    cfg_write[1] = 0; cfg_addr[1] = 5; cfg_bl[1] = 2;
    rbeat[0] = 16'hA5A5; rbeat[1] = 16'h5A5A;
    do_burst(2'b10, 1'b1);

    // Clamp to MAX_BURST and zero-length burst
    cfg_write[0] = 1; cfg_addr[0] = 100; cfg_bl[0] = 15;
    for (int i = 0; i < MAXB; i++) begin wbeat[i] = DW'($urandom); rbeat[i] = DW'($urandom); end
    do_burst(2'b01, 1'b0);
    cfg_write[1] = 0; cfg_addr[1] = 200; cfg_bl[1] = 0;
    do_burst(2'b10, 1'b0);

    // Address wrap
    cfg_write[0] = 1; cfg_addr[0] = 32'h1FFFF; cfg_bl[0] = 2;
    do_burst(2'b01, 1'b1);

    // Reset one cycle after the first read accept
    cfg_write[1] = 0; cfg_addr[1] = 9; cfg_bl[1] = 4;
    next_cycle();
    drive_ports(2'b10);
    main_state = SW'(SRD); clk_slow_posedge = 1'b1; clk180_slow_posedge = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      next_cycle();
      data_from_ram = DW'($urandom);
      #1;
      if (beat_ack[1]) got = 1'b1;
    end
    check("rstrd_first_accept", 32'(got), 1);
    check("rstrd_grant", 32'(grant), 32'(oh(1)));
    next_cycle();
    reset = 1'b1; req = '0;
    #1;
    check("rstrd_ack_in_reset", 32'(beat_ack), 0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("rstrd_grant0", 32'(grant), 0);
    check("rstrd_ack0", 32'(beat_ack), 0);
    check("rstrd_rvalid0", 32'(rvalid), 0);
    check("rstrd_rdata0", 32'(rdata), 0);
    check("rstrd_en0", {30'd0, write_enable, read_enable}, 0);
    check("rstrd_addr0", 32'(i_user_data_address), 0);
    check("rstrd_wdata0", 32'(data_to_ram), 0);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      #1;
      check("rstrd_no_rvalid", 32'(rvalid), 0);
    end
    rr_ptr = NP - 1;
    pending.delete();
    cfg_write[0] = 1; cfg_addr[0] = 7; cfg_bl[0] = 1;
    cfg_write[1] = 1; cfg_addr[1] = 8; cfg_bl[1] = 1;
    do_burst(2'b11, 1'b0);

    // Round-robin with both ports requesting continuously
    do_reset();
    cfg_write[0] = 1; cfg_bl[0] = 1; cfg_write[1] = 1; cfg_bl[1] = 1;
    next_cycle();
    drive_ports(2'b11);
    main_state = SW'(SWD); clk_slow_posedge = 1'b1; clk180_slow_posedge = 1'b1;
    prev_g = '0;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      if (k == 30) req = '0;
      #1;
      check("rr_onehot", 32'($countones(grant) <= 1), 1);
      if (grant != '0 && prev_g == '0) seg_owner.push_back($clog2(grant));
      if (grant != '0 && prev_g != '0) check("rr_gap", 32'(grant), 32'(prev_g));
      prev_g = grant;
    end
    check("rr_final_idle", 32'(grant), 0);
    check("rr_segments", 32'(seg_owner.size() >= 4), 1);
    foreach (seg_owner[i]) check("rr_order", 32'(seg_owner[i]), 32'(i % NP));
    if (seg_owner.size() > 0) rr_ptr = seg_owner[seg_owner.size() - 1];

    // Random bursts
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < NP; p++) begin
        cfg_write[p] = 1'($urandom);
        cfg_addr[p]  = int'($urandom_range((1 << AW) - 1, 0));
        cfg_bl[p]    = int'($urandom_range(15, 0));
      end
      for (int i = 0; i < MAXB; i++) begin wbeat[i] = DW'($urandom); rbeat[i] = DW'($urandom); end
      do_burst(NP'($urandom_range((1 << NP) - 1, 1)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_user_port_arbiter.md
Name: ddr3_user_port_arbiter

Overview:
Shares the single user port of ddr3_memory_controller (write_enable, read_enable, i_user_data_address, data_to_ram, data_from_ram) between NUM_PORTS requesters. The arbiter grants whole bursts in round-robin order and paces write beats from the controller's main_state and slow-clock phase strobes. It returns read data to the owning requester through a fixed-latency valid pipeline. It sits between user logic (e.g. the loopback generator) and ddr3_memory_controller.

Parameters:
NUM_PORTS, 2, number of requesters (2..4)
ADDR_WIDTH, 17, bank+row/col user address width (3+14)
DQ_BITWIDTH, 16, data beat width
BURST_WIDTH, 4, width of per-port burst length field
MAX_BURST, 8, beat cap per grant; keeps refresh postponement within the 8-command budget
READ_LATENCY, 2, clk cycles from read beat accept to data_from_ram valid
STATE_WRITE_DATA, 8, controller main_state code for the write data phase
STATE_READ_DATA, 11, controller main_state code for the read data phase
STATE_WIDTH, 5, main_state width

Ports:
clk  in  1  host clock
reset  in  1  synchronous, active-high
req  in  NUM_PORTS  request level, per port
is_write  in  NUM_PORTS  1=write burst, 0=read burst
addr  in  NUM_PORTS*ADDR_WIDTH  start address, per port
wdata  in  NUM_PORTS*DQ_BITWIDTH  current write beat, per port
burst_len  in  NUM_PORTS*BURST_WIDTH  beats requested, per port
grant  out  NUM_PORTS  one-hot owner indication
beat_ack  out  NUM_PORTS  1-cycle pulse when a beat is accepted
rdata  out  DQ_BITWIDTH  read data, shared by all ports
rvalid  out  NUM_PORTS  1-cycle pulse qualifying rdata for the owning port
main_state  in  STATE_WIDTH  controller state
clk_slow_posedge  in  1  controller phase strobe
clk180_slow_posedge  in  1  controller phase strobe
write_enable  out  1  to controller
read_enable  out  1  to controller
i_user_data_address  out  ADDR_WIDTH  to controller
data_to_ram  out  DQ_BITWIDTH  to controller
data_from_ram  in  DQ_BITWIDTH  from controller

Behaviour:
- Reset values: all outputs 0. State=IDLE. Round-robin pointer=NUM_PORTS-1. Read pipeline flushed. Reset mid-burst aborts the burst immediately; no further beat_ack or rvalid.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: if any req is set, pick the first set port scanning from pointer+1 (modulo NUM_PORTS). Latch its addr, is_write and burst length.
  - burst_len=0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
  - Next cycle: grant[owner]=1, and write_enable=1 (go to WRITE) or read_enable=1 (go to READ).
- req is sampled only in IDLE. Deassertion mid-burst is ignored and the burst completes.
- WRITE:
  - data_to_ram = owner's wdata (combinational mux). i_user_data_address = current address.
  - Beat accept = (main_state==STATE_WRITE_DATA) & (clk_slow_posedge | clk180_slow_posedge).
  - On accept: beat_ack[owner] pulses, address increments (wraps modulo 2^ADDR_WIDTH), remaining count decrements.
  - The requester presents the next wdata in the cycle after beat_ack.
- READ:
  - Beat accept = (main_state==STATE_READ_DATA) & clk_slow_posedge.
  - On accept: address increments, count decrements, beat_ack pulses, and a valid token tagged with the owner enters a READ_LATENCY-deep shift pipeline.
  - At pipeline exit: rdata <= data_from_ram and rvalid[owner] pulses. Read data therefore returns READ_LATENCY+1 cycles after accept.
- Last beat: on the cycle the last beat is accepted, the enable clears at the next edge and the FSM moves to DRAIN. No beat is accepted after the count reaches 0.
- DRAIN: wait until the read pipeline is empty (immediate for writes). Then clear grant, set pointer=owner, return to IDLE. There is always at least 1 idle cycle between grants.
- Beat accepts are never generated outside WRITE/READ, even if main_state matches.
- Exactly one grant bit is set at any time, or none.

Test Plan:
- Single write: port0 req, is_write=1, addr=0, burst_len=3, wdata 0x0100/0x0302/0x0504 updated after each ack. Required: 3 beat_ack[0] pulses, i_user_data_address 0,1,2, write_enable falls the cycle after the 3rd accept, grant[0] clears after DRAIN.
- Read latency: port1 read, addr=5, burst_len=2, main_state=11, data_from_ram driven to 0xA5A5 then 0x5A5A. Required: rvalid[1] pulses exactly READ_LATENCY+1 cycles after each accept, with rdata=0xA5A5 then 0x5A5A.
- Round-robin: both ports hold req continuously with burst_len=1. Required: grants alternate 0,1,0,1 starting with port0 after reset, with an idle cycle between each grant.
- Clamp and zero: burst_len=15 gives exactly 8 beat_acks. burst_len=0 gives exactly 1 beat_ack.
- Address wrap: addr=0x1FFFF, burst_len=2 write. Required: i_user_data_address 0x1FFFF then 0x00000.
- Reset mid-read: assert reset 1 cycle after the 1st read accept. Required: all outputs 0 on the next cycle, no rvalid afterwards, next grant goes to port0.
